// File: rtl/iq_upsample.sv
// iq_upsample: symbol FIFO feeding an OSR-times upsampler
// (hold or zero-stuff) for the BPSK transmit path.
module iq_upsample #(
  parameter int OSR    = 4,
  parameter int DEPTH  = 8,
  parameter int PRIME  = 2,
  parameter int ZSTUFF = 0
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    valid_x,
  input  logic signed [10:0]      xr,
  input  logic signed [10:0]      xi,
  input  logic                    tick_i,
  input  logic                    clr_i,
  output logic signed [10:0]      yr,
  output logic signed [10:0]      yi,
  output logic                    valid_y,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    full,
  output logic                    running,
  output logic                    overflow,
  output logic                    underrun
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int PW = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [LW-1:0] L_MAX   = LW'(DEPTH);
  localparam logic [LW-1:0] L_PRIME = LW'(PRIME);
  localparam logic [PW-1:0] PH_LAST = PW'(OSR - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  logic [21:0]        mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [PW-1:0]      phase;
  logic [PW-1:0]      ph_next;
  logic signed [10:0] cur_r;
  logic signed [10:0] cur_i;
  logic [21:0]        head;
  logic               start;
  logic               sym_due;
  logic               pop;
  logic               push;
  logic               ov_set;
  logic               un_set;

  assign head    = mem[rd_ptr];
  assign full    = (level == L_MAX);
  assign running = (state == RUN);
  assign ph_next = (phase == PH_LAST) ? '0 : phase + PW'(1);

  // A symbol boundary in RUN either pops the next symbol or starves.
  assign start   = tick_i && (state == IDLE) && (level >= L_PRIME);
  assign sym_due = tick_i && (state == RUN) && (phase == '0);
  assign pop     = start || (sym_due && (level != '0));
  assign un_set  = sym_due && (level == '0);
  assign push    = valid_x && (!full || pop);
  assign ov_set  = valid_x && full && !pop;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      phase    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      cur_r    <= '0;
      cur_i    <= '0;
      yr       <= '0;
      yi       <= '0;
      valid_y  <= 1'b0;
      overflow <= 1'b0;
      underrun <= 1'b0;
    end else begin
      valid_y <= tick_i;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)
        level <= level + LW'(1);
      else if (pop && !push)
        level <= level - LW'(1);
      if (pop) begin
        state <= RUN;
        phase <= ph_next;
        cur_r <= head[21:11];
        cur_i <= head[10:0];
        yr    <= head[21:11];
        yi    <= head[10:0];
      end else if (tick_i) begin
        if (state == RUN && phase != '0) begin
          phase <= ph_next;
          yr    <= (ZSTUFF != 0) ? '0 : cur_r;
          yi    <= (ZSTUFF != 0) ? '0 : cur_i;
        end else begin
          state <= IDLE;
          phase <= '0;
          yr    <= '0;
          yi    <= '0;
        end
      end
      if (ov_set)     overflow <= 1'b1;
      else if (clr_i) overflow <= 1'b0;
      if (un_set)     underrun <= 1'b1;
      else if (clr_i) underrun <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= {xr, xi};
  end

endmodule

// File: tb/tb_iq_upsample.sv
// tb_iq_upsample: hold and zero-stuff instances on shared stimulus,
// checked against a queue-based model of the upsampler.
module tb_iq_upsample;
  localparam int OSR   = 4;
  localparam int DEPTH = 8;
  localparam int PRIME = 2;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic valid_x = 1'b0;
  logic tick_i = 1'b0;
  logic clr_i = 1'b0;
  logic signed [10:0] xr = '0;
  logic signed [10:0] xi = '0;

  logic signed [10:0] yr0, yi0, yr1, yi1;
  logic vy0, vy1, full0, full1, run0, run1;
  logic ov0, ov1, un0, un1;
  logic [3:0] lvl0, lvl1;

  int vectors = 0;
  int miscompares = 0;

  logic [21:0] q[$];
  bit m_run, m_vy, m_ov, m_un;
  int m_ph, m_cr, m_ci;
  int e_yr0, e_yi0, e_yr1, e_yi1;

  iq_upsample #(.OSR(OSR), .DEPTH(DEPTH), .PRIME(PRIME), .ZSTUFF(0)) u0 (
    .CLK(CLK), .RST(RST), .valid_x(valid_x), .xr(xr), .xi(xi),
    .tick_i(tick_i), .clr_i(clr_i), .yr(yr0), .yi(yi0),
    .valid_y(vy0), .level(lvl0), .full(full0), .running(run0),
    .overflow(ov0), .underrun(un0));

  iq_upsample #(.OSR(OSR), .DEPTH(DEPTH), .PRIME(PRIME), .ZSTUFF(1)) u1 (
    .CLK(CLK), .RST(RST), .valid_x(valid_x), .xr(xr), .xi(xi),
    .tick_i(tick_i), .clr_i(clr_i), .yr(yr1), .yi(yi1),
    .valid_y(vy1), .level(lvl1), .full(full1), .running(run1),
    .overflow(ov1), .underrun(un1));

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_run = 0; m_vy = 0; m_ov = 0; m_un = 0;
    m_ph = 0; m_cr = 0; m_ci = 0;
    e_yr0 = 0; e_yi0 = 0; e_yr1 = 0; e_yi1 = 0;
  endtask

  task automatic emit(input int r0, input int i0, input int r1, input int i1);
    e_yr0 = r0; e_yi0 = i0; e_yr1 = r1; e_yi1 = i1;
  endtask

  // One clock of the spec's behaviour, evaluated on pre-edge inputs.
  task automatic model_step();
    bit pop = 0;
    bit ov = 0;
    bit un = 0;
    int sz = q.size();
    logic [21:0] h;
    logic signed [10:0] t;
    if (tick_i) begin
      if ((!m_run && sz >= PRIME) || (m_run && m_ph == 0 && sz > 0)) begin
        h = q.pop_front();
        pop = 1;
        m_run = 1;
        t = h[21:11]; m_cr = int'(t);
        t = h[10:0];  m_ci = int'(t);
        emit(m_cr, m_ci, m_cr, m_ci);
        m_ph = 1 % OSR;
      end else if (m_run && m_ph == 0) begin
        un = 1;
        m_run = 0;
        emit(0, 0, 0, 0);
      end else if (m_run) begin
        emit(m_cr, m_ci, 0, 0);
        m_ph = (m_ph + 1) % OSR;
      end else begin
        emit(0, 0, 0, 0);
      end
    end
    if (valid_x) begin
      if (sz < DEPTH || pop) q.push_back({xr, xi});
      else ov = 1;
    end
    m_vy = tick_i;
    m_ov = ov ? 1'b1 : (clr_i ? 1'b0 : m_ov);
    m_un = un ? 1'b1 : (clr_i ? 1'b0 : m_un);
  endtask

  task automatic check_all();
    chk("yr_hold", yr0, e_yr0);
    chk("yi_hold", yi0, e_yi0);
    chk("yr_zstuff", yr1, e_yr1);
    chk("yi_zstuff", yi1, e_yi1);
    chk("valid_y", {vy1, vy0}, {m_vy, m_vy});
    chk("level", lvl0, q.size());
    chk("level_z", lvl1, q.size());
    chk("full", {full1, full0}, {2{q.size() == DEPTH}});
    chk("running", {run1, run0}, {m_run, m_run});
    chk("overflow", {ov1, ov0}, {m_ov, m_ov});
    chk("underrun", {un1, un0}, {m_un, m_un});
  endtask

  task automatic step(input bit vx, input bit tk, input bit clr,
                      input int r, input int i);
    valid_x = vx; tick_i = tk; clr_i = clr;
    xr = 11'(r); xi = 11'(i);
    @(posedge CLK);
    model_step();
    #1;
    check_all();
  endtask

  function automatic int pm8();
    return ($urandom_range(0, 1) != 0) ? 8 : -8;
  endfunction

  function automatic int rnd11();
    return int'($urandom_range(0, 2047)) - 1024;
  endfunction

  task automatic hard_reset();
    #2;
    RST = 1'b0;
    model_reset();
    #1;
    check_all();
    #2;
    RST = 1'b1;
  endtask

  initial begin
    model_reset();
    #3;
    check_all();
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;

    // first tick after reset: zero sample in IDLE
    step(0, 1, 0, 0, 0);

    // hold / zero-stuff run: +8,-8,+8 pushed with a tick every cycle
    step(1, 1, 0, 8, pm8());
    step(1, 1, 0, -8, pm8());
    step(1, 1, 0, 8, pm8());
    repeat (15) step(0, 1, 0, 0, 0);
    chk("hold_underrun", un0, 1);
    chk("hold_idle", run0, 0);
    step(0, 0, 1, 0, 0);
    chk("clr_underrun", un0, 0);

    // overflow: nine pushes with no ticks
    for (int k = 0; k < 9; k++) step(1, 0, 0, rnd11(), rnd11());
    chk("ovf_level", lvl0, 8);
    chk("ovf_flag", ov0, 1);
    step(0, 0, 1, 0, 0);

    // full with pop: pushes coincide with symbol-boundary pops
    step(1, 1, 0, rnd11(), rnd11());
    repeat (3) step(0, 1, 0, 0, 0);
    step(1, 1, 0, rnd11(), rnd11());
    chk("fullpop_level", lvl0, 8);
    chk("fullpop_ovf", ov0, 0);
    repeat (44) step(0, 1, 0, 0, 0);

    // prime: one symbol is not enough to start
    step(0, 0, 1, 0, 0);
    step(1, 0, 0, 8, -8);
    step(0, 1, 0, 0, 0);
    chk("prime_wait", run0, 0);
    step(1, 0, 0, -8, 8);
    step(0, 1, 0, 0, 0);
    chk("prime_start", run0, 1);
    repeat (12) step(0, 1, 0, 0, 0);

    // randomized traffic at several push/tick densities
    for (int seg = 0; seg < 4; seg++) begin
      for (int n = 0; n < 600; n++) begin
        step($urandom_range(0, 2 + 4 * seg) == 0,
             $urandom_range(0, 1) == 0,
             $urandom_range(0, 31) == 0,
             (seg == 0) ? pm8() : rnd11(),
             (seg == 0) ? pm8() : rnd11());
      end
    end

    // reset mid-symbol: RUN, phase 2, level 3
    hard_reset();
    for (int k = 0; k < 4; k++) step(1, 0, 0, pm8(), pm8());
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("pre_rst_level", lvl0, 3);
    hard_reset();
    chk("rst_level", lvl0, 0);
    chk("rst_yr", yr0, 0);
    step(0, 1, 0, 0, 0);
    repeat (4) step(1, 1, 0, rnd11(), rnd11());
    repeat (20) step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("final_clr", un0, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/iq_upsample.md
IQ_UPSAMPLE -- requirements
Module: iq_upsample

Interface
REQ-001 SHALL have parameter OSR, default 4, samples per symbol (2..16).
REQ-002 SHALL have parameter DEPTH, default 8, symbol FIFO entries (power of two, 4..32).
REQ-003 SHALL have parameter PRIME, default 2, FIFO level required to start emitting (1..DEPTH).
REQ-004 SHALL have parameter ZSTUFF, default 0; 0 = hold symbol for OSR samples, 1 = symbol then OSR-1 zeros.
REQ-005 CLK  input  1  single clock; all logic on rising edge.
REQ-006 RST  input  1  asynchronous, active-low reset.
REQ-007 valid_x  input  1  symbol strobe from BPSK mapper.
REQ-008 xr, xi  input  11 each  signed symbol (mapper produces +-8).
REQ-009 tick_i  input  1  output-sample strobe (DAC rate).
REQ-010 clr_i  input  1  synchronous clear of sticky flags.
REQ-011 yr, yi  output  11 each  signed upsampled samples.
REQ-012 valid_y  output  1  one-cycle pulse per emitted sample.
REQ-013 level  output  $clog2(DEPTH)+1  FIFO occupancy.
REQ-014 full  output  1  level == DEPTH.
REQ-015 running  output  1  high in RUN state.
REQ-016 overflow, underrun  output  1 each  sticky error flags.

Function
REQ-017 SHALL push {xr,xi} into FIFO on valid_x when level < DEPTH, or when level == DEPTH and a pop occurs the same cycle.
REQ-018 SHALL drop the symbol and set overflow when valid_x arrives with level == DEPTH and no same-cycle pop.
REQ-019 SHALL keep a phase counter 0..OSR-1, advanced only on tick_i, wrapping OSR-1 -> 0.
REQ-020 SHALL have states IDLE and RUN; reset enters IDLE with phase = 0.
REQ-021 IDLE: on each tick_i emit yr = yi = 0 with valid_y; phase held at 0; no pops.
REQ-022 IDLE -> RUN on a tick_i when level >= PRIME (registered level); that tick pops the head symbol and emits it, phase -> 1 (or 0 when OSR wraps).
REQ-023 RUN: on tick_i with phase == 0 and level > 0, pop head and emit it.
REQ-024 RUN: on tick_i with phase == 0 and level == 0, emit zeros, set underrun, go IDLE, phase stays 0.
REQ-025 RUN: on tick_i with phase != 0, emit current symbol (ZSTUFF=0) or zeros (ZSTUFF=1).
REQ-026 No bypass: a symbol pushed in cycle t is poppable from cycle t+1.
REQ-027 Outputs registered: yr/yi/valid_y update in cycle after tick_i (latency 1); yr/yi hold value between ticks.
REQ-028 Simultaneous push and pop SHALL leave level unchanged; pointers wrap modulo DEPTH.
REQ-029 clr_i SHALL clear overflow and underrun; a same-cycle set event wins over clr_i.
REQ-030 Sample values SHALL pass unmodified (no scaling, no sign change).

Reset
REQ-031 While RST low: yr = yi = 0, valid_y = 0, level = 0, full = 0, running = 0, overflow = underrun = 0, FIFO pointers = 0, state IDLE.
REQ-032 Reset asserted mid-symbol SHALL discard FIFO contents and current symbol immediately (asynchronously).
REQ-033 First tick_i after RST release SHALL produce a zero sample in IDLE.

Verification
REQ-034 Hold: OSR=4, push +8,-8,+8, tick every cycle -> after priming, yr = 8,8,8,8,-8,-8,-8,-8,8,8,8,8 then zeros, underrun = 1, running = 0.
REQ-035 Zero-stuff: ZSTUFF=1, push +8,-8 -> yr = 8,0,0,0,-8,0,0,0; yi equals xi per symbol.
REQ-036 Overflow: DEPTH=8, no ticks, push 9 symbols -> level = 8, full = 1, overflow = 1, ninth dropped; draining yields first 8 in order.
REQ-037 Full with pop: level = 8, valid_x coincident with a phase-0 tick in RUN -> push accepted, level stays 8, overflow = 0.
REQ-038 Prime: PRIME=2, push 1 symbol, tick -> zeros, running = 0; push second -> next tick emits first symbol, running = 1.
REQ-039 Reset mid-run: assert RST during phase 2 of a symbol with level = 3 -> all outputs zero, level = 0 immediately; clr_i after a flag set clears it next cycle.
